// File: rtl/d_mem_write_arbiter_if.sv
// Requester-side and D-memory-side signals of the write arbiter.
// master: the arbiter; slave: requesters plus the D-memory write interface.
interface d_mem_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 5,
  parameter int DW      = 8
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    ack;
  logic                  wr_start;
  logic [AW-1:0]         addr_out;
  logic [DW-1:0]         data_out;
  logic                  wr_done;

  modport master (
    input  req, req_addr, req_data, wr_done,
    output ack, wr_start, addr_out, data_out
  );

  modport slave (
    output req, req_addr, req_data, wr_done,
    input  ack, wr_start, addr_out, data_out
  );
endinterface

// File: rtl/d_mem_write_arbiter.sv
// Round-robin arbiter sharing the D-memory write port among NUM_REQ cores,
// with a wr_done watchdog, sticky timeout flag and saturating write counter.
module d_mem_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  d_mem_write_arbiter_if.master      bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [AW:0]                wr_count
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0]      WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0]      LAST_ID = GW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t              state;
  logic [GW-1:0]       rr_ptr;
  logic [GW-1:0]       pick_idx;
  logic [GW-1:0]       cand_idx;
  logic                pick_valid;
  logic [WW-1:0]       watchdog;
  logic [NUM_REQ-1:0]  ack_r;
  logic                wr_start_r;
  logic [AW-1:0]       addr_r;
  logic [DW-1:0]       data_r;

  assign bus.ack      = ack_r;
  assign bus.wr_start = wr_start_r;
  assign bus.addr_out = addr_r;
  assign bus.data_out = data_r;

  // First pending requester at or above rr_ptr, wrapping to 0.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_idx = GW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!pick_valid && bus.req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      watchdog    <= '0;
      grant_id    <= '0;
      addr_r      <= '0;
      data_r      <= '0;
      wr_start_r  <= 1'b0;
      ack_r       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wr_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id   <= pick_idx;
            addr_r     <= bus.req_addr[pick_idx*AW +: AW];
            data_r     <= bus.req_data[pick_idx*DW +: DW];
            wr_start_r <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          wr_start_r <= 1'b0;
          watchdog   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          // wr_done takes priority, so a completion on the last watchdog cycle is a success.
          if (bus.wr_done) begin
            if (wr_count != '1) wr_count <= wr_count + 1'b1;
            ack_r <= ONE_HOT << grant_id;
            state <= ACK;
          end else if (watchdog == WD_LAST) begin
            timeout_err <= 1'b1;
            ack_r       <= ONE_HOT << grant_id;
            state       <= ACK;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        ACK: begin
          ack_r  <= '0;
          rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/d_mem_write_arbiter.md
Name: d_mem_write_arbiter

Overview:
- Round-robin arbiter that shares the single decrypted-message (D) memory write port among NUM_REQ requesters (cracking/decrypt cores).
- Sits upstream of the D-memory write interface. Latches one requester's address/data, issues a one-cycle wr_start, waits for wr_done, then returns a one-cycle ack to the winner.
- Includes a wr_done watchdog with a sticky error flag, and a count of completed writes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- AW, 5, memory address width
- DW, 8, memory data width
- TIMEOUT, 16, maximum WAIT cycles before abort (≥ 4)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level; held until ack
- req_addr  in  NUM_REQ*AW  packed addresses; requester i at bits [i*AW +: AW]
- req_data  in  NUM_REQ*DW  packed data; requester i at bits [i*DW +: DW]
- ack  out  NUM_REQ  one-hot, one-cycle pulse: write for that requester finished
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on any watchdog abort
- wr_count  out  AW+1  completed successful writes, saturating at all-ones
- wr_start  out  1  one-cycle start pulse to the D-memory write interface
- addr_out  out  AW  latched address, held stable from wr_start until wr_done
- data_out  out  DW  latched data, held stable from wr_start until wr_done
- wr_done  in  1  one-cycle completion pulse from the D-memory write interface

Behaviour:
- Reset values: ack=0, wr_start=0, busy=0, timeout_err=0, wr_count=0, grant_id=0, addr_out=0, data_out=0, rr_ptr=0, watchdog=0, state=IDLE.
- Reset asserted in any state returns to IDLE on that edge. An in-flight write is abandoned and no ack is issued.
- FSM states: IDLE, START, WAIT, ACK.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …).
  - Latch grant_id, addr_out = req_addr[grant], data_out = req_data[grant], then go to START.
  - Otherwise stay in IDLE.
- START:
  - wr_start=1 for exactly this one cycle; clear the watchdog; go to WAIT.
- WAIT:
  - On wr_done=1: go to ACK and increment wr_count, saturating.
  - Otherwise increment the watchdog. When the watchdog reaches TIMEOUT-1 with wr_done=0: set timeout_err, go to ACK, and leave wr_count unchanged.
  - If wr_done and the timeout coincide in the same cycle, the write counts as a success.
- ACK:
  - ack[grant_id]=1 for exactly this one cycle.
  - rr_ptr = (grant_id+1) mod NUM_REQ; go to IDLE.
- wr_done outside WAIT is ignored.
- Requester rules:
  - Hold req, address and data stable from assertion until its ack.
  - Drop req on the edge that samples ack. A req still high in the following IDLE cycle is treated as a new request.
- addr_out and data_out change only in IDLE on a grant.
- Latency with the standard write interface (IDLE→SETUP→WRITE→DONE):
  - req high in cycle 0 (arbiter idle) → wr_start in cycle 1 → wr_done in cycle 4 → ack in cycle 5 → IDLE in cycle 6.
  - Back-to-back throughput is one write per 6 cycles.
- Fairness: a requester with req held waits at most NUM_REQ-1 other services.
- Changes to the req vector outside IDLE do not affect the current transaction.

Test Plan:
- Single write: reset, then req=4'b0001, addr=5'd3, data=8'hA5 → wr_start in cycle 1 with addr_out=3 and data_out=A5; ack=4'b0001 in cycle 5; wr_count=1; busy low in cycle 6.
- All requesters at once: req=4'b1111 held (each dropped on its own ack) → grants in order 0,1,2,3, acks 6 cycles apart, wr_count=4.
- Round-robin wrap: after serving requester 2, assert req=4'b0101 → requester 0 is skipped in favour of rr_ptr=3? No: rr_ptr=3 finds no req at 3, wraps, and grants 0, then 2 → grant order 0, 2.
- Watchdog: wr_done tied low, TIMEOUT=16 → ack pulses 16 cycles after wr_start+1, timeout_err=1 and stays set, wr_count unchanged. Next request proceeds normally.
- Coincident done and timeout: wr_done arrives exactly on watchdog=TIMEOUT-1 → timeout_err stays 0 and wr_count increments.
- Reset mid-write: assert reset during WAIT → next cycle busy=0, wr_start=0, no ack issued, wr_count=0, rr_ptr=0; a fresh req=4'b0010 is served normally.
